// File: rtl/datapath_host_pkg.sv
// Shared widths and TX state encoding for the datapath host port.
package datapath_host_pkg;

  localparam int unsigned DEF_BEAT_W = 64;
  localparam int unsigned DEF_BLK_W  = 2 * DEF_BEAT_W;
  localparam int unsigned DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LO   = 2'd1,
    TX_HI   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/block_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers wrap at DEPTH-1 so any depth works.
module block_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/datapath_host_port.sv
// Host port: splits 128-bit blocks into two datapath beats, reassembles responses into a result FIFO.
module datapath_host_port
  import datapath_host_pkg::*;
#(
  parameter int unsigned BEAT_W = DEF_BEAT_W,
  parameter int unsigned BLK_W  = 2 * BEAT_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              blk_in_valid,
  output logic              blk_in_ready,
  input  logic [BLK_W-1:0]  blk_in_data,
  output logic              dp_valid,
  output logic [BEAT_W-1:0] dp_data,
  input  logic              dp_rsp_valid,
  input  logic [BEAT_W-1:0] dp_rsp_data,
  output logic              blk_out_valid,
  input  logic              blk_out_ready,
  output logic [BLK_W-1:0]  blk_out_data,
  output logic [CNT_W-1:0]  in_flight,
  output logic              err_unexpected
);

  localparam int unsigned SUM_W = CNT_W + 1;

  tx_state_t         state;
  tx_state_t         state_n;
  logic [BEAT_W-1:0] hi_q;
  logic [BEAT_W-1:0] hi_n;
  logic              dp_valid_n;
  logic [BEAT_W-1:0] dp_data_n;
  logic              accept;
  logic              pop;
  logic              push;
  logic              unexpected;
  logic              rx_hi;
  logic [BEAT_W-1:0] rx_lo;
  logic [SUM_W-1:0]  credits_used;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  // A pop this cycle frees its slot immediately, so credits are counted net of it.
  assign pop           = blk_out_valid && blk_out_ready;
  assign credits_used  = SUM_W'(in_flight) + SUM_W'(fifo_count) - SUM_W'(pop);
  assign blk_in_ready  = !reset && (state != TX_LO) && (credits_used < SUM_W'(DEPTH));
  assign accept        = blk_in_valid && blk_in_ready;
  assign blk_out_valid = !fifo_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= TX_IDLE;
      hi_q     <= '0;
      dp_valid <= 1'b0;
      dp_data  <= '0;
    end else begin
      state    <= state_n;
      hi_q     <= hi_n;
      dp_valid <= dp_valid_n;
      dp_data  <= dp_data_n;
    end
  end

  // Accepting in TX_HI chains straight into the next low beat.
  always_comb begin
    state_n    = state;
    hi_n       = hi_q;
    dp_valid_n = 1'b0;
    dp_data_n  = '0;
    case (state)
      TX_IDLE, TX_HI: begin
        if (accept) begin
          state_n    = TX_LO;
          hi_n       = blk_in_data[BLK_W-1:BEAT_W];
          dp_valid_n = 1'b1;
          dp_data_n  = blk_in_data[BEAT_W-1:0];
        end else begin
          state_n = TX_IDLE;
        end
      end
      TX_LO: begin
        state_n    = TX_HI;
        dp_valid_n = 1'b1;
        dp_data_n  = hi_q;
      end
      default: state_n = TX_IDLE;
    endcase
  end

  // Stray low-phase beats with nothing outstanding are dropped and flagged.
  assign unexpected = dp_rsp_valid && !rx_hi && (in_flight == '0);
  assign push       = dp_rsp_valid && rx_hi;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_hi          <= 1'b0;
      rx_lo          <= '0;
      in_flight      <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (dp_rsp_valid && !unexpected) rx_hi <= !rx_hi;
      if (dp_rsp_valid && !rx_hi && !unexpected) rx_lo <= dp_rsp_data;
      if (unexpected) err_unexpected <= 1'b1;
      in_flight <= in_flight + CNT_W'(accept) - CNT_W'(push);
    end
  end

  block_fifo #(
    .WIDTH (BLK_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({dp_rsp_data, rx_lo}),
    .pop       (pop),
    .pop_data  (blk_out_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_no_push_full: assert property (@(posedge clock) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_datapath_host_port.sv
// Bench for datapath_host_port with a fixed-latency bitwise-negating datapath model.
module tb_datapath_host_port;

  localparam int unsigned BEAT_W = 64;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DP_LAT = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              blk_in_valid;
  logic              blk_in_ready;
  logic [BLK_W-1:0]  blk_in_data;
  logic              dp_valid;
  logic [BEAT_W-1:0] dp_data;
  logic              dp_rsp_valid;
  logic [BEAT_W-1:0] dp_rsp_data;
  logic              blk_out_valid;
  logic              blk_out_ready;
  logic [BLK_W-1:0]  blk_out_data;
  logic [CNT_W-1:0]  in_flight;
  logic              err_unexpected;

  logic              inj_valid;
  logic [BEAT_W-1:0] inj_data;
  logic [BEAT_W:0]   pipe [DP_LAT];

  int                n_checks = 0;
  int                n_errors = 0;
  bit                last_acc;
  logic [BLK_W-1:0]  exp_q [$];

  typedef struct {
    logic [BLK_W-1:0]  blk;
    logic [BEAT_W-1:0] exp_lo;
    logic [BEAT_W-1:0] exp_hi;
    logic [BLK_W-1:0]  exp_out;
  } vec_t;
  vec_t vecs [4];

  always #5 clock = ~clock;

  datapath_host_port dut (
    .clock          (clock),
    .reset          (reset),
    .blk_in_valid   (blk_in_valid),
    .blk_in_ready   (blk_in_ready),
    .blk_in_data    (blk_in_data),
    .dp_valid       (dp_valid),
    .dp_data        (dp_data),
    .dp_rsp_valid   (dp_rsp_valid),
    .dp_rsp_data    (dp_rsp_data),
    .blk_out_valid  (blk_out_valid),
    .blk_out_ready  (blk_out_ready),
    .blk_out_data   (blk_out_data),
    .in_flight      (in_flight),
    .err_unexpected (err_unexpected)
  );

  // Datapath model: negates each beat, fixed latency, flushed by reset.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DP_LAT); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {dp_valid, ~dp_data};
      for (int i = 1; i < int'(DP_LAT); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dp_rsp_valid = pipe[DP_LAT-1][BEAT_W] | inj_valid;
  assign dp_rsp_data  = inj_valid ? inj_data : pipe[DP_LAT-1][BEAT_W-1:0];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [BLK_W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One cycle from a negedge: log accepts into the scoreboard, compare pops, move to next negedge.
  task automatic tick();
    logic [BLK_W-1:0] e;
    #1;
    last_acc = blk_in_valid && blk_in_ready;
    if (last_acc) exp_q.push_back(~blk_in_data);
    if (blk_out_valid && blk_out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_extra actual=%h required=none", blk_out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", blk_out_data, e);
      end
    end
    @(negedge clock);
  endtask

  task automatic wait_idle();
    int n = 0;
    blk_out_ready = 1'b1;
    while (!(exp_q.size() == 0 && in_flight == '0 && !blk_out_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", 128'(n < 200), 128'(1));
  endtask

  task automatic send_n(input int n);
    int acc = 0;
    int c = 0;
    blk_in_valid = 1'b1;
    blk_in_data  = rnd128();
    while (acc < n && c < 100) begin
      tick();
      c++;
      if (last_acc) begin
        acc++;
        blk_in_data = rnd128();
      end
    end
    blk_in_valid = 1'b0;
    chk("send_count", 128'(acc), 128'(n));
  endtask

  initial begin
    int acc;
    int dv_cnt;
    int first;
    int last;
    int n_rsp;
    int c;
    bit done;
    logic [BLK_W-1:0] exp_b;

    vecs[0] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 64'hFEDCBA9876543210,
                64'h0123456789ABCDEF, 128'hFEDCBA9876543210_0123456789ABCDEF};
    vecs[1] = '{128'h0, 64'h0, 64'h0, {BLK_W{1'b1}}};
    vecs[2] = '{128'hFFFFFFFFFFFFFFFF_0000000000000000, 64'h0,
                64'hFFFFFFFFFFFFFFFF, 128'h0000000000000000_FFFFFFFFFFFFFFFF};
    vecs[3] = '{128'hAAAAAAAAAAAAAAAA_5555555555555555, 64'h5555555555555555,
                64'hAAAAAAAAAAAAAAAA, 128'h5555555555555555_AAAAAAAAAAAAAAAA};

    reset         = 1'b1;
    blk_in_valid  = 1'b0;
    blk_in_data   = '0;
    blk_out_ready = 1'b0;
    inj_valid     = 1'b0;
    inj_data      = '0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_ready", 128'(blk_in_ready), 128'(0));
    chk("rst_dp_valid", 128'(dp_valid), 128'(0));
    chk("rst_dp_data", 128'(dp_data), 128'(0));
    chk("rst_out_valid", 128'(blk_out_valid), 128'(0));
    chk("rst_in_flight", 128'(in_flight), 128'(0));
    chk("rst_err", 128'(err_unexpected), 128'(0));
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 128'(blk_in_ready), 128'(1));
    @(negedge clock);

    // Single blocks: beat order, negation, latency
    foreach (vecs[k]) begin
      wait_idle();
      blk_in_valid = 1'b1;
      blk_in_data  = vecs[k].blk;
      tick();
      chk("v_accept", 128'(last_acc), 128'(1));
      blk_in_valid = 1'b0;
      blk_in_data  = '0;
      chk("v_lo_valid", 128'(dp_valid), 128'(1));
      chk("v_lo_data", 128'(dp_data), 128'(vecs[k].exp_lo));
      tick();
      chk("v_hi_valid", 128'(dp_valid), 128'(1));
      chk("v_hi_data", 128'(dp_data), 128'(vecs[k].exp_hi));
      tick();
      chk("v_idle_valid", 128'(dp_valid), 128'(0));
      tick();
      chk("v_out_early", 128'(blk_out_valid), 128'(0));
      tick();
      chk("v_out_valid", 128'(blk_out_valid), 128'(1));
      chk("v_out_data", blk_out_data, vecs[k].exp_out);
      chk("v_in_flight", 128'(in_flight), 128'(0));
    end
    wait_idle();

    // Credit limit: four accepts with no pops, then a pop opens ready the same cycle
    blk_out_ready = 1'b0;
    blk_in_valid  = 1'b1;
    blk_in_data   = rnd128();
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_acc) begin
        acc++;
        blk_in_data = rnd128();
      end
    end
    chk("credit_accepts", 128'(acc), 128'(DEPTH));
    chk("credit_ready_low", 128'(blk_in_ready), 128'(0));
    chk("credit_out_valid", 128'(blk_out_valid), 128'(1));
    blk_out_ready = 1'b1;
    #1;
    chk("credit_ready_on_pop", 128'(blk_in_ready), 128'(1));
    tick();
    chk("credit_fifth_accept", 128'(last_acc), 128'(1));
    blk_in_valid  = 1'b0;
    blk_out_ready = 1'b0;
    wait_idle();

    // Back-to-back stream of ten blocks
    blk_out_ready = 1'b1;
    blk_in_valid  = 1'b1;
    blk_in_data   = rnd128();
    acc = 0; dv_cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 60; i++) begin
      if (dp_valid) begin
        dv_cnt++;
        if (first < 0) first = i;
        last = i;
      end
      tick();
      if (last_acc) begin
        acc++;
        if (acc == 10) blk_in_valid = 1'b0;
        else blk_in_data = rnd128();
      end
    end
    chk("b2b_accepts", 128'(acc), 128'(10));
    chk("b2b_beats", 128'(dv_cnt), 128'(20));
    chk("b2b_span", 128'(last - first + 1), 128'(20));
    wait_idle();
    chk("b2b_err", 128'(err_unexpected), 128'(0));

    // Push and pop in the same cycle at count 2
    blk_out_ready = 1'b0;
    send_n(2);
    c = 0;
    while (in_flight != '0 && c < 100) begin
      tick();
      c++;
    end
    chk("pp_settle", 128'(c < 100), 128'(1));
    chk("pp_count_pre", 128'(dut.u_fifo.count), 128'(2));
    exp_b = exp_q[1];
    send_n(1);
    n_rsp = 0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (dp_rsp_valid) n_rsp++;
      if (n_rsp == 2) begin
        blk_out_ready = 1'b1;
        done = 1'b1;
      end
      tick();
      blk_out_ready = 1'b0;
    end
    chk("pp_reached", 128'(done), 128'(1));
    chk("pp_count_post", 128'(dut.u_fifo.count), 128'(2));
    chk("pp_head", blk_out_data, exp_b);
    wait_idle();

    // Unexpected response beat
    chk("unexp_err_pre", 128'(err_unexpected), 128'(0));
    inj_valid = 1'b1;
    inj_data  = {$urandom(), $urandom()};
    tick();
    inj_valid = 1'b0;
    chk("unexp_err_set", 128'(err_unexpected), 128'(1));
    chk("unexp_out_valid", 128'(blk_out_valid), 128'(0));
    chk("unexp_in_flight", 128'(in_flight), 128'(0));
    repeat (5) tick();
    chk("unexp_err_sticky", 128'(err_unexpected), 128'(1));
    chk("unexp_count", 128'(dut.u_fifo.count), 128'(0));

    // Reset asserted while in TX_LO
    blk_in_valid = 1'b1;
    blk_in_data  = rnd128();
    tick();
    blk_in_valid = 1'b0;
    chk("rlo_dp_valid_pre", 128'(dp_valid), 128'(1));
    reset = 1'b1;
    #1;
    chk("rlo_ready", 128'(blk_in_ready), 128'(0));
    exp_q.delete();
    @(negedge clock);
    chk("rlo_dp_valid", 128'(dp_valid), 128'(0));
    chk("rlo_in_flight", 128'(in_flight), 128'(0));
    chk("rlo_out_valid", 128'(blk_out_valid), 128'(0));
    chk("rlo_err", 128'(err_unexpected), 128'(0));
    reset = 1'b0;
    repeat (6) tick();
    chk("rlo_err_after", 128'(err_unexpected), 128'(0));
    chk("rlo_out_after", 128'(blk_out_valid), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
